// File: rtl/hazard_pkg.sv
// Shared types for the hazard/forwarding unit: forward-select encoding,
// controller states and the hard-wired zero register index.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_REG    = 2'b00,
        FWD_MEM_WB = 2'b01,
        FWD_EX_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        STALL = 2'b01,
        FLUSH = 2'b10
    } hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand forwarding priority comparator: EX/MEM result beats MEM/WB,
// writes to $0 never forward. Also flags an EX-stage producer hit for load-use.
module hazard_fwd_sel
    import hazard_pkg::*;
(
    input  logic       en,
    input  logic [4:0] src,
    input  logic [4:0] dest_ex,
    input  logic       wr_ex,
    input  logic [4:0] dest_mem,
    input  logic       wr_mem,
    output fwd_sel_t   sel,
    output logic       ex_hit
);

    logic mem_hit;

    always_comb begin
        ex_hit  = en && wr_ex && (dest_ex != REG_ZERO) && (dest_ex == src);
        mem_hit = en && wr_mem && (dest_mem != REG_ZERO) && (dest_mem == src);
        if (ex_hit) begin
            sel = FWD_EX_MEM;
        end else if (mem_hit) begin
            sel = FWD_MEM_WB;
        end else begin
            sel = FWD_REG;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard detection and registered forward-select generation for the EX stage.
// Define HAZARD_STATS_EN to build the saturating stall/flush/forward counters.
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ip_valid_ID,
    input  logic [4:0]       ip_rs_ID,
    input  logic [4:0]       ip_rt_ID,
    input  logic             ip_uses_rt_ID,
    input  logic [4:0]       ip_dest_reg_EX,
    input  logic             ip_RegWrite_EX,
    input  logic             ip_read_en_EX,
    input  logic [4:0]       ip_dest_reg_MEM,
    input  logic             ip_RegWrite_MEM,
    input  logic             ip_branch_MEM,
    input  logic             ip_zero_MEM,
    output logic [1:0]       op_FA,
    output logic [1:0]       op_FB,
    output logic             op_stall,
    output logic             op_bubble,
    output logic             op_flush,
    output logic [CNT_W-1:0] op_stall_count,
    output logic [CNT_W-1:0] op_flush_count,
    output logic [CNT_W-1:0] op_fwd_count
);

    // Counter holds remaining FLUSH cycles minus one, so 2 bits cover 1..3.
    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

    hz_state_t  state_reg, state_next;
    logic [1:0] flush_cnt_reg, flush_cnt_next;
    fwd_sel_t   fa_reg, fa_next, fb_reg, fb_next;
    fwd_sel_t   sel_a, sel_b;
    logic       hit_a, hit_b;
    logic       branch_taken, load_use, flush_now, load_fwd;

    hazard_fwd_sel u_sel_rs (
        .en       (1'b1),
        .src      (ip_rs_ID),
        .dest_ex  (ip_dest_reg_EX),
        .wr_ex    (ip_RegWrite_EX),
        .dest_mem (ip_dest_reg_MEM),
        .wr_mem   (ip_RegWrite_MEM),
        .sel      (sel_a),
        .ex_hit   (hit_a)
    );

    hazard_fwd_sel u_sel_rt (
        .en       (ip_uses_rt_ID),
        .src      (ip_rt_ID),
        .dest_ex  (ip_dest_reg_EX),
        .wr_ex    (ip_RegWrite_EX),
        .dest_mem (ip_dest_reg_MEM),
        .wr_mem   (ip_RegWrite_MEM),
        .sel      (sel_b),
        .ex_hit   (hit_b)
    );

    always_comb begin
        branch_taken   = ip_branch_MEM && ip_zero_MEM;
        // A taken branch squashes the load-use victim, so flush wins over stall.
        load_use       = ip_valid_ID && ip_read_en_EX && (hit_a || hit_b)
                         && (state_reg == RUN) && !branch_taken;
        flush_now      = branch_taken || (state_reg == FLUSH);
        load_fwd       = ip_valid_ID && !load_use && !flush_now;
        fa_next        = load_fwd ? sel_a : FWD_REG;
        fb_next        = load_fwd ? sel_b : FWD_REG;

        state_next     = state_reg;
        flush_cnt_next = flush_cnt_reg;
        if (branch_taken) begin
            state_next     = FLUSH;
            flush_cnt_next = FLUSH_LOAD;
        end else begin
            case (state_reg)
                RUN:     if (load_use) state_next = STALL;
                STALL:   state_next = RUN;
                FLUSH: begin
                    if (flush_cnt_reg == '0) state_next = RUN;
                    else flush_cnt_next = flush_cnt_reg - 2'd1;
                end
                default: state_next = RUN;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= RUN;
            flush_cnt_reg <= '0;
            fa_reg        <= FWD_REG;
            fb_reg        <= FWD_REG;
        end else begin
            state_reg     <= state_next;
            flush_cnt_reg <= flush_cnt_next;
            fa_reg        <= fa_next;
            fb_reg        <= fb_next;
        end
    end

    // Reset masks the combinational controls so a pending stall/flush drops at once.
    assign op_FA     = fa_reg;
    assign op_FB     = fb_reg;
    assign op_stall  = load_use && !reset;
    assign op_bubble = load_use && !reset;
    assign op_flush  = flush_now && !reset;

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_stat_reg, fwd_cnt_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt_reg      <= '0;
            flush_cnt_stat_reg <= '0;
            fwd_cnt_reg        <= '0;
        end else begin
            if (load_use && (stall_cnt_reg != '1))
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            if (branch_taken && (flush_cnt_stat_reg != '1))
                flush_cnt_stat_reg <= flush_cnt_stat_reg + CNT_W'(1);
            if (((fa_next != FWD_REG) || (fb_next != FWD_REG)) && (fwd_cnt_reg != '1))
                fwd_cnt_reg <= fwd_cnt_reg + CNT_W'(1);
        end
    end

    assign op_stall_count = stall_cnt_reg;
    assign op_flush_count = flush_cnt_stat_reg;
    assign op_fwd_count   = fwd_cnt_reg;
`else
    assign op_stall_count = '0;
    assign op_flush_count = '0;
    assign op_fwd_count   = '0;
`endif

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
Hazard-detection and forwarding-select generator for the 5-stage MIPS pipeline. It is the producer side of the EX-stage operand-forwarding interface (FA/FB). It inspects the instruction in ID against in-flight writers and registers the forward selects so they are valid when that instruction enters EX. It also generates load-use stalls and sequences the flush after a taken branch resolved in MEM.

Parameters:
FLUSH_CYCLES, 1, number of consecutive cycles op_flush is held after a taken branch (1..3)
CNT_W, 32, width of statistics counters (used only with HAZARD_STATS_EN)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
ip_valid_ID  in  1  ID holds a real instruction
ip_rs_ID  in  5  rs of instruction in ID
ip_rt_ID  in  5  rt of instruction in ID
ip_uses_rt_ID  in  1  instruction in ID reads rt as an ALU/store operand
ip_dest_reg_EX  in  5  destination of instruction in EX (post RegDst mux)
ip_RegWrite_EX  in  1  EX instruction writes a register
ip_read_en_EX  in  1  EX instruction is a load
ip_dest_reg_MEM  in  5  destination of instruction in MEM
ip_RegWrite_MEM  in  1  MEM instruction writes a register
ip_branch_MEM  in  1  MEM instruction is a branch
ip_zero_MEM  in  1  branch condition true
op_FA  out  2  forward select, A operand of EX
op_FB  out  2  forward select, B operand of EX
op_stall  out  1  hold PC and IF/ID register
op_bubble  out  1  load zeros into ID/EX control fields
op_flush  out  1  squash IF/ID, ID/EX, EX/MEM
op_stall_count  out  CNT_W  load-use stalls taken
op_flush_count  out  CNT_W  taken-branch flushes
op_fwd_count  out  CNT_W  EX entries with any nonzero forward select

Behaviour:
- Forward encoding: 00 register file; 10 EX/MEM ALU result; 01 MEM/WB (EX stage muxes read data vs ALU result via MemtoReg).
- Next-select per operand, computed in ID:
  - 10 if RegWrite_EX, dest_EX != 0 and dest_EX == src.
  - Else 01 if RegWrite_MEM, dest_MEM != 0 and dest_MEM == src.
  - Else 00. 10 has priority over 01.
  - FB evaluated only when ip_uses_rt_ID; otherwise 00.
- Register file is write-before-read; no WB->ID forwarding case exists.
- op_FA/op_FB are registered, with 1-cycle latency. Update rules:
  - Load on a normal advance.
  - Clear to 00 on bubble or flush.
  - Clear to 00 when ip_valid_ID=0.
- Load-use: ip_read_en_EX & ip_RegWrite_EX & dest_EX != 0 & dest_EX matches a used ID source & ip_valid_ID. When this holds:
  - op_stall=1 and op_bubble=1, combinationally in that cycle.
  - FA/FB registers load 00.
- Next cycle the load is in MEM; re-evaluation yields 01.
- FSM states: RUN, STALL, FLUSH.
  - RUN -> STALL on load-use.
  - STALL -> RUN unconditionally after 1 cycle; load-use detection is suppressed in STALL.
  - Any state -> FLUSH on ip_branch_MEM & ip_zero_MEM.
  - FLUSH holds for FLUSH_CYCLES via down-counter, then -> RUN.
- op_flush = 1 on the detection cycle and every FLUSH cycle.
- Flush beats stall: on a simultaneous taken branch and load-use, op_stall=0, op_bubble=0, op_flush=1.
- During FLUSH, op_stall=0 and FA/FB are held at 00.
- A new taken branch while in FLUSH reloads the counter.
- Reset (async) drives: FA=FB=00, op_stall=op_bubble=op_flush=0, state RUN, flush counter 0, stats 0. Reset mid-stall or mid-flush abandons it immediately.

Optional Feature:
HAZARD_STATS_EN:
- Defined: three saturating CNT_W counters.
  - op_stall_count +1 per RUN->STALL.
  - op_flush_count +1 per taken-branch detection.
  - op_fwd_count +1 per cycle where the registered FA or FB changes to nonzero on load.
  - Counters saturate at all-ones.
- Undefined: counters not instantiated; outputs tied to 0.

Decomposition:
- Package hazard_pkg contains:
  - fwd_sel_t enum (FWD_REG=2'b00, FWD_MEM_WB=2'b01, FWD_EX_MEM=2'b10).
  - hz_state_t enum (RUN, STALL, FLUSH).
  - REG_ZERO=5'd0.
- Sub-module hazard_fwd_sel: per-operand priority comparator, instantiated twice (rs, rt).

Test Plan:
- add $3 in EX (RegWrite, dest 3); ID reads rs=3 -> next cycle op_FA=10, op_FB=00.
- $3 written by MEM instr and by EX instr; ID rs=3 -> op_FA=10 (priority); with EX dest=4 instead -> op_FA=01.
- lw $5 in EX (read_en); ID add uses rt=5, uses_rt=1:
  - Detection cycle: op_stall=1, op_bubble=1.
  - Next cycle: stall=0, FB loads 01.
  - stall_count=1 with HAZARD_STATS_EN.
- dest=$0 with RegWrite in EX and MEM; ID rs=rt=0 -> FA=FB=00, no stall.
- FLUSH_CYCLES=2; taken branch (branch_MEM=1, zero_MEM=1) coincident with load-use -> op_flush=1 for 3 consecutive cycles, op_stall never 1, FA/FB=00 throughout.
- Assert reset during STALL -> op_stall falls immediately, all outputs 0; after release, state RUN.
